// File: rtl/spi_chain_pkg.sv
// Shared types and helpers for the SPI-loaded configuration register chain.
// SPI_CHAIN_PARITY_EN adds a trailing even-parity bit to every frame.
package spi_chain_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int PAR_MAX_W = 256;

   function automatic int frame_w(input int addr_w, input int data_w);
`ifdef SPI_CHAIN_PARITY_EN
      return addr_w + data_w + 1;
`else
      return addr_w + data_w;
`endif
   endfunction

   // Zero padding leaves the XOR reduction unaffected.
   function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/spi_chain_regs_if.sv
// Pad-side serial port plus core-side register outputs of spi_chain_regs.
// The slave modport is the register bank; the master drives the pads.
interface spi_chain_regs_if #(
   parameter int DATA_W = 16,
   parameter int NUM_CH = 4
);

   logic                     i_spi_clk;
   logic                     i_spi_dat;
   logic                     i_spi_load;
   logic                     o_spi_dat;
   logic                     o_det;
   logic                     o_err;
   logic                     o_busy;
   logic [NUM_CH*DATA_W-1:0] o_data;

   modport master (
      output i_spi_clk,
      output i_spi_dat,
      output i_spi_load,
      input  o_spi_dat,
      input  o_det,
      input  o_err,
      input  o_busy,
      input  o_data
   );

   modport slave (
      input  i_spi_clk,
      input  i_spi_dat,
      input  i_spi_load,
      output o_spi_dat,
      output o_det,
      output o_err,
      output o_busy,
      output o_data
   );

endinterface

// File: rtl/spi_chain_regs_sync.sv
// One-bit multi-flop synchroniser with an edge-detect flop.
// Produces the synchronised level and single-cycle rise/fall strobes.
module spi_chain_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] ff_q;
   logic              prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff_q   <= '0;
         prev_q <= 1'b0;
      end else begin
         ff_q   <= {ff_q[STAGES-2:0], d};
         prev_q <= ff_q[STAGES-1];
      end
   end

   assign q    = ff_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_chain_regs.sv
// NUM_CH x DATA_W register bank loaded by addressed serial frames.
// Define SPI_CHAIN_PARITY_EN to require a trailing even-parity bit.
module spi_chain_regs
   import spi_chain_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int NUM_CH      = 4,
   parameter int ADDR_W      = $clog2(NUM_CH),
   parameter int SYNC_STAGES = 2
) (
   input logic             i_clk,
   input logic             i_reset,
   spi_chain_regs_if.slave bus
);

   localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int CNT_W   = $clog2(FRAME_W + 2);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
   localparam logic [ADDR_W:0]  CH_LIM   = (ADDR_W + 1)'(NUM_CH);

   logic clk_lvl;
   logic clk_rise;
   logic clk_fall;
   logic dat_lvl;
   logic dat_rise;
   logic dat_fall;
   logic load_lvl;
   logic load_rise;
   logic load_fall;
   logic unused_edges;

   state_t state_q;
   state_t state_d;

   logic [FRAME_W-1:0]       sr_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [NUM_CH*DATA_W-1:0] data_q;
   logic                     det_q;
   logic                     err_q;

   logic              shift_en;
   logic              commit;
   logic              frame_ok;
   logic              par_ok;
   logic [ADDR_W-1:0] f_addr;
   logic [DATA_W-1:0] f_data;

   spi_chain_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .clk  (i_clk),
      .rst  (i_reset),
      .d    (bus.i_spi_clk),
      .q    (clk_lvl),
      .rise (clk_rise),
      .fall (clk_fall)
   );

   spi_chain_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
      .clk  (i_clk),
      .rst  (i_reset),
      .d    (bus.i_spi_dat),
      .q    (dat_lvl),
      .rise (dat_rise),
      .fall (dat_fall)
   );

   spi_chain_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
      .clk  (i_clk),
      .rst  (i_reset),
      .d    (bus.i_spi_load),
      .q    (load_lvl),
      .rise (load_rise),
      .fall (load_fall)
   );

   assign unused_edges = ^{clk_lvl, clk_fall, dat_rise, dat_fall};

   assign f_addr = sr_q[FRAME_W-1 -: ADDR_W];
   assign f_data = sr_q[FRAME_W-1-ADDR_W -: DATA_W];

`ifdef SPI_CHAIN_PARITY_EN
   // Even parity over the whole frame, parity bit included, must be 0.
   assign par_ok = ~parity(PAR_MAX_W'(sr_q));
`else
   assign par_ok = 1'b1;
`endif

   assign frame_ok = (cnt_q == CNT_FULL) &&
                     ({1'b0, f_addr} < CH_LIM) &&
                     par_ok;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A load rise in SHIFT takes priority over a coincident clk rise.
   always_comb begin
      state_d  = state_q;
      shift_en = 1'b0;
      commit   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_fall) state_d = SHIFT;
         end
         SHIFT: begin
            if (load_rise) state_d = COMMIT;
            else           shift_en = clk_rise;
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = load_fall ? SHIFT : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (shift_en) begin
            sr_q <= {sr_q[FRAME_W-2:0], dat_lvl};
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
         end
         if (commit) cnt_q <= '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         data_q <= '0;
         det_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         det_q <= 1'b0;
         err_q <= 1'b0;
         if (commit) begin
            if (frame_ok) begin
               det_q <= 1'b1;
               for (int k = 0; k < NUM_CH; k++) begin
                  if ({1'b0, f_addr} == (ADDR_W + 1)'(k))
                     data_q[k*DATA_W +: DATA_W] <= f_data;
               end
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.o_spi_dat = sr_q[FRAME_W-1];
   assign bus.o_det     = det_q;
   assign bus.o_err     = err_q;
   assign bus.o_busy    = (cnt_q != '0) && !load_lvl;
   assign bus.o_data    = data_q;

endmodule
